// File: rtl/fre_calc.sv
// Frequency calculator: F = N * F_REF / M via a 64-iteration restoring divider.
// Optional FRE_CALC_ROUND_EN: round-to-nearest (ties up) instead of truncation.
module fre_calc #(
  parameter int unsigned F_REF     = 100_000_000,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [31:0] M_in,
  input  logic [31:0] N_in,
  input  logic        irq,
  output logic [31:0] fre_out,
  output logic        fre_valid,
  output logic        busy,
  output logic        div0,
  output logic        sat,
  output logic        ovr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned ProdBits = 32 + $clog2(F_REF) + FRAC_BITS;

  if (ProdBits > 64 || FRAC_BITS > 4) begin : g_param_check
    $error("fre_calc: F_REF/FRAC_BITS overflow the 64-bit numerator");
  end

  logic [1:0]  state_q;
  logic        irq_q;
  logic [31:0] m_q;
  logic [31:0] n_q;
  logic [63:0] num_q;
  logic [32:0] rem_q;
  logic [63:0] quo_q;
  logic [5:0]  cnt_q;

  logic        edge_det;
  logic [63:0] num_init;
  logic [32:0] rem_sh;
  logic [32:0] rem_nx;
  logic [63:0] quo_nx;
  logic        ge;

  assign edge_det = irq & ~irq_q;
  // Dropped events are flagged in the same cycle as the offending edge.
  assign ovr      = edge_det & (state_q != IDLE);

  always_comb begin
    num_init = (64'(n_q) * 64'(F_REF)) << FRAC_BITS;
`ifdef FRE_CALC_ROUND_EN
    num_init = num_init + 64'(m_q >> 1);
`endif
    rem_sh = {rem_q[31:0], num_q[63]};
    ge     = (rem_sh >= {1'b0, m_q});
    rem_nx = ge ? (rem_sh - {1'b0, m_q}) : rem_sh;
    quo_nx = {quo_q[62:0], ge};
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      fre_out   <= '0;
      fre_valid <= 1'b0;
      busy      <= 1'b0;
      div0      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      irq_q <= irq;
      unique case (state_q)
        IDLE: begin
          if (edge_det) begin
            m_q     <= M_in;
            n_q     <= N_in;
            busy    <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (m_q == '0) begin
            fre_out   <= 32'hFFFF_FFFF;
            div0      <= 1'b1;
            sat       <= 1'b0;
            fre_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            num_q   <= num_init;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          num_q <= {num_q[62:0], 1'b0};
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 6'd1;
          // Result is registered straight from the final iteration's quotient.
          if (cnt_q == 6'd63) begin
            if (quo_nx[63:32] != '0) begin
              fre_out <= 32'hFFFF_FFFF;
              sat     <= 1'b1;
            end else begin
              fre_out <= quo_nx[31:0];
              sat     <= 1'b0;
            end
            div0      <= 1'b0;
            fre_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          fre_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fre_calc.sv
// Scoreboard bench for fre_calc: stimulus pushes expected results, a monitor pops on fre_valid.
module tb_fre_calc;

  logic        clk_100M = 1'b0;
  logic        rst_n;
  logic [31:0] M_in, N_in;
  logic        irq;
  logic [31:0] fre_out;
  logic        fre_valid, busy, div0, sat, ovr;

  typedef struct {
    logic [31:0] fre;
    logic        div0;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fre_calc dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .M_in      (M_in),
    .N_in      (N_in),
    .irq       (irq),
    .fre_out   (fre_out),
    .fre_valid (fre_valid),
    .busy      (busy),
    .div0      (div0),
    .sat       (sat),
    .ovr       (ovr)
  );

  always #5 clk_100M = ~clk_100M;
  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fre_valid must match the oldest outstanding expectation.
  always @(negedge clk_100M) begin
    if (rst_n === 1'b1 && fre_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got fre_out=0x%0h with no job pending (cycle %0d)",
                 fre_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fre_out", 64'(fre_out), 64'(e.fre));
        check("div0", 64'(div0), 64'(e.div0));
        check("sat", 64'(sat), 64'(e.sat));
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called just after a posedge; the current cycle is the edge cycle (cycle 0).
  task automatic edge_in(input logic [31:0] m, input logic [31:0] n, input bit push,
                         input logic [31:0] fre, input logic d0, input logic st,
                         input int lat, input logic exp_ovr);
    exp_t e;
    M_in = m;
    N_in = n;
    irq  = 1'b1;
    if (push) begin
      e.fre  = fre;
      e.div0 = d0;
      e.sat  = st;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk_100M);
    check("ovr_on_edge", 64'(ovr), 64'(exp_ovr));
    @(posedge clk_100M);
    #1 irq = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk_100M);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk_100M);
  endtask

  task automatic next_cycle();
    @(posedge clk_100M);
    #1;
  endtask

  logic [31:0] exp_third;
  logic [31:0] exp_fresh;

  initial begin
`ifdef FRE_CALC_ROUND_EN
    exp_third = 32'd66_666_667;
    exp_fresh = 32'd4;
`else
    exp_third = 32'd66_666_666;
    exp_fresh = 32'd3;
`endif
    rst_n = 1'b0;
    irq   = 1'b0;
    M_in  = '0;
    N_in  = '0;
    #13;
    check("rst_fre_out", 64'(fre_out), 64'd0);
    check("rst_valid", 64'(fre_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flags", 64'({div0, sat, ovr}), 64'd0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // Nominal job with busy window checks (busy high cycles 1..66).
    edge_in(32'd100_000_000, 32'd1_000_000, 1'b1, 32'd1_000_000, 1'b0, 1'b0, 66, 1'b0);
    @(negedge clk_100M);
    check("busy_cycle1", 64'(busy), 64'd1);
    repeat (65) @(negedge clk_100M);
    check("busy_cycle66", 64'(busy), 64'd1);
    @(negedge clk_100M);
    check("busy_cycle67", 64'(busy), 64'd0);
    check("valid_cycle67", 64'(fre_valid), 64'd0);
    wait_done(10);

    next_cycle();
    edge_in(32'd3, 32'd2, 1'b1, exp_third, 1'b0, 1'b0, 66, 1'b0);
    wait_done(100);

    next_cycle();
    edge_in(32'd0, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, 1'b0);
    wait_done(20);
    check("div0_hold", 64'(div0), 64'd1);

    next_cycle();
    edge_in(32'd1, 32'd100, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 66, 1'b0);
    wait_done(100);
    check("sat_hold", 64'(sat), 64'd1);

    next_cycle();
    edge_in(32'd100_000_000, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 66, 1'b0);
    wait_done(100);
    check("fre_out_hold", 64'(fre_out), 64'd1);

    // Overlapping edge in cycle 10 is dropped; edge in cycle 70 is accepted.
    next_cycle();
    edge_in(32'd100_000_000, 32'd12_345, 1'b1, 32'd12_345, 1'b0, 1'b0, 66, 1'b0);
    repeat (9) next_cycle();
    edge_in(32'd7, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
    check("ovr_pulse_width", 64'(ovr), 64'd0);
    repeat (59) next_cycle();
    edge_in(32'd50_000_000, 32'd3, 1'b1, 32'd6, 1'b0, 1'b0, 66, 1'b0);
    wait_done(200);

    // Reset in cycle 30 of a job aborts it without a result.
    next_cycle();
    edge_in(32'd4, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (29) next_cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_fre_out", 64'(fre_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_flags", 64'({fre_valid, div0, sat, ovr}), 64'd0);
    repeat (3) next_cycle();
    rst_n = 1'b1;
    repeat (80) next_cycle();
    edge_in(32'd200_000_000, 32'd7, 1'b1, exp_fresh, 1'b0, 1'b0, 66, 1'b0);
    wait_done(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
